multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Parametrised multi-cycle successor to the single-cycle LEGv8 opcode decoder.
// - Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath controls per state.
// - Handles variable-latency memory through a req/ready handshake with timeout, flags illegal opcodes, counts retired instructions.
// - Sits between the instruction register / memory port and the shared datapath (regfile, ALU, PC).
// PARAMETERS
// OPCODE_W     11   opcode field width, instr[31:21]; classes below are defined on the top 11 bits
// ALUOP_W      2    alu_op width to the ALU control
// TIMEOUT_W    4    width of memory-wait counter
// MEM_TIMEOUT  15   cycles waiting for mem_ready before bus_error; 0 disables timeout
// CNT_W        32   retired-instruction counter width, wraps modulo 2^CNT_W
// TRAP_ILLEGAL 0    1: illegal opcode parks FSM in TRAP until reset; 0: skip and refetch
// PORTS
// clk          in   1          rising-edge clock
// rst_n        in   1          synchronous active-low reset
// opcode       in   OPCODE_W   instruction opcode field from IR, sampled in DECODE
// zero         in   1          ALU zero flag, sampled in EXEC
// mem_ready    in   1          memory completes current request this cycle
// mem_req      out  1          memory request (fetch or data)
// mem_we       out  1          memory write (STUR data phase only)
// ir_write     out  1          load IR
// pc_write     out  1          update PC
// pc_src       out  1          0: PC+4, 1: branch target
// reg2loc      out  1          regfile read-port-2 select (1 = Rt field)
// alu_src      out  1          ALU B operand: 0 reg, 1 sign-extended imm
// mem_to_reg   out  1          writeback source: 1 memory, 0 ALU
// reg_write    out  1          regfile write enable
// alu_op       out  ALUOP_W    00 add, 01 pass-B/zero test, 10 R-type funct
// retire       out  1          one-cycle pulse per completed instruction
// illegal      out  1          one-cycle pulse on undecodable opcode
// bus_error    out  1          one-cycle pulse on memory timeout
// retired_cnt  out  CNT_W      retired-instruction count
// state        out  3          FSM state, debug
// BEHAVIOUR
// - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Reset: state=FETCH, retired_cnt=0, wait counter=0, class=NONE.
// - While rst_n=0 every output is 0 (incl. mem_req). First post-reset cycle: FETCH with mem_req=1.
// - Classes, latched in DECODE: R=1xx0101x000, LDUR=11111000010, STUR=11111000000, CBZ=10110100xxx, B=000101xxxxx; else ILL. First match wins in that order.
// - FETCH: mem_req=1, mem_we=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0 same cycle (Mealy); next DECODE. Otherwise hold.
// - DECODE: latch class. ILL: illegal=1, next TRAP if TRAP_ILLEGAL else FETCH, no retire. Otherwise next EXEC.
// - EXEC controls: R: alu_src=0, alu_op=10, next WB. LDUR/STUR: alu_src=1, alu_op=00, next MEM. STUR also reg2loc=1.
// - EXEC CBZ: reg2loc=1, alu_op=01. If zero=1: pc_write=1, pc_src=1. Always retire=1, next FETCH.
// - EXEC B: pc_write=1, pc_src=1, retire=1, next FETCH.
// - MEM: mem_req=1, mem_we=(class==STUR). On mem_ready: LDUR next WB; STUR retire=1, next FETCH.
// - WB: reg_write=1, mem_to_reg=(class==LDUR), retire=1, next FETCH.
// - Controls not listed for a state are 0. alu_src, alu_op and reg2loc hold their EXEC values through MEM/WB so datapath operands stay stable.
// - Timeout: wait counter clears on entry to FETCH/MEM and on mem_ready, and increments each cycle mem_req=1 && !mem_ready, saturating.
// - When count reaches MEM_TIMEOUT with mem_ready=0: bus_error=1, no ir_write/retire, next FETCH.
// - In FETCH, a timeout refetches the same PC. mem_ready in the timeout cycle wins (normal completion).
// - retired_cnt increments by 1 on every retire cycle and wraps from 2^CNT_W-1 to 0.
// - TRAP: all controls 0, held until rst_n=0. opcode/zero/mem_ready are ignored outside their sampling states.
// - Reset mid-instruction: next edge returns to FETCH, clears counters and class, drops any in-flight request.
// TESTING
// - R-type 10001011000, mem_ready=1 in FETCH -> states 0,1,2,4,0; reg_write=1 in WB; alu_op=10; retire once; retired_cnt=1.
// - LDUR 11111000010 with 3 wait cycles in MEM -> mem_req held 4 cycles, mem_we=0; WB has mem_to_reg=1, reg_write=1.
// - STUR 11111000000 -> MEM mem_we=1, reg2loc=1; no reg_write; returns to FETCH; retire=1 on mem_ready cycle.
// - CBZ 10110100xxx with zero=1 and zero=0 -> pc_write&pc_src=1 only when zero=1; both retire after 3 cycles.
// - Opcode 00000000000 -> illegal pulse, back to FETCH (TRAP_ILLEGAL=0) or state=5 sticky (=1); retired_cnt unchanged.
// - MEM_TIMEOUT=15, mem_ready never high -> bus_error on the 15th wait cycle, FSM in FETCH next.
// - rst_n low in MEM -> FSM in FETCH and outputs 0 next cycle.
// - CNT_W=4: 16 B instructions -> retired_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Multi-cycle control unit for a LEGv8-style datapath. Each instruction is
// sequenced through FETCH/DECODE/EXEC/MEM/WB. The unit drives the datapath
// controls for the current state, talks to a variable-latency memory through a
// req/ready handshake with a wait-cycle timeout, flags undecodable opcodes and
// counts retired instructions.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; all outputs forced to 0 while low
//   opcode       instr[31:21] from the IR, sampled in DECODE
//   zero         ALU zero flag, sampled in EXEC (CBZ)
//   mem_ready    memory completes the current request this cycle
//   mem_req      memory request (fetch or data phase)
//   mem_we       memory write (STUR data phase)
//   ir_write     load instruction register
//   pc_write     update PC
//   pc_src       0: PC+4, 1: branch target
//   reg2loc      regfile read-port-2 select (1 = Rt field)
//   alu_src      ALU B operand: 0 register, 1 sign-extended immediate
//   mem_to_reg   writeback source: 1 memory, 0 ALU
//   reg_write    regfile write enable
//   alu_op       00 add, 01 pass-B/zero test, 10 R-type funct
//   retire       one-cycle pulse per completed instruction
//   illegal      one-cycle pulse on an undecodable opcode
//   bus_error    one-cycle pulse on a memory timeout
//   retired_cnt  retired-instruction count (wraps)
//   state        FSM state for debug
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OPCODE_W     = 11,
  parameter int ALUOP_W      = 2,
  parameter int TIMEOUT_W    = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 32,
  parameter int TRAP_ILLEGAL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2loc,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                retire,
  output logic                illegal,
  output logic                bus_error,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
  } class_e;

  localparam logic [ALUOP_W-1:0]   ALU_ADD   = '0;
  localparam logic [ALUOP_W-1:0]   ALU_PASSB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0]   ALU_RTYPE = ALUOP_W'(2);
  localparam bit                   TO_EN     = (MEM_TIMEOUT != 0);
  // Count value at the start of the last permitted wait cycle.
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TO_EN ? TIMEOUT_W'(MEM_TIMEOUT - 1) : '0;

  state_e               state_q, state_d;
  class_e               class_q, class_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  class_e               dec_class;
  logic [10:0]          op_top;
  logic                 timeout;

  logic req, we, irw, pcw, pcs, r2l, asrc, m2r, rw, ret, ill, berr;
  logic [ALUOP_W-1:0] aop;

  assign op_top = opcode[OPCODE_W-1 -: 11];

  // casez order gives first-match priority between overlapping patterns.
  always_comb begin
    casez (op_top)
      11'b1??0101?000: dec_class = C_R;
      11'b11111000010: dec_class = C_LDUR;
      11'b11111000000: dec_class = C_STUR;
      11'b10110100???: dec_class = C_CBZ;
      11'b000101?????: dec_class = C_B;
      default:         dec_class = C_ILL;
    endcase
  end

  // A ready response in the last permitted cycle still completes normally.
  assign timeout = TO_EN && !mem_ready && (wait_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cnt_d   = cnt_q;
    req  = 1'b0; we  = 1'b0; irw = 1'b0; pcw  = 1'b0; pcs = 1'b0; r2l = 1'b0;
    asrc = 1'b0; m2r = 1'b0; rw  = 1'b0; ret  = 1'b0; ill = 1'b0; berr = 1'b0;
    aop  = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          // PC was not advanced, so staying in FETCH refetches the same word.
          berr = 1'b1;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_class == C_ILL) begin
          ill     = 1'b1;
          state_d = (TRAP_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_R: begin
            aop     = ALU_RTYPE;
            state_d = S_WB;
          end
          C_LDUR, C_STUR: begin
            asrc    = 1'b1;
            r2l     = (class_q == C_STUR);
            state_d = S_MEM;
          end
          C_CBZ: begin
            r2l     = 1'b1;
            aop     = ALU_PASSB;
            pcw     = zero;
            pcs     = zero;
            ret     = 1'b1;
            state_d = S_FETCH;
          end
          C_B: begin
            pcw     = 1'b1;
            pcs     = 1'b1;
            ret     = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Operand selects keep their EXEC values so the address stays stable.
        req  = 1'b1;
        we   = (class_q == C_STUR);
        r2l  = (class_q == C_STUR);
        asrc = 1'b1;
        if (mem_ready) begin
          if (class_q == C_STUR) begin
            ret     = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          berr    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        m2r     = (class_q == C_LDUR);
        asrc    = (class_q == C_LDUR);
        aop     = (class_q == C_R) ? ALU_RTYPE : ALU_ADD;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Any state change (or a timeout refetch) starts a fresh wait window.
    if (mem_ready || berr || (state_d != state_q)) begin
      wait_d = '0;
    end else if (req && (wait_q != {TIMEOUT_W{1'b1}})) begin
      wait_d = wait_q + TIMEOUT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    if (ret) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      class_q <= C_NONE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign mem_req     = rst_n & req;
  assign mem_we      = rst_n & we;
  assign ir_write    = rst_n & irw;
  assign pc_write    = rst_n & pcw;
  assign pc_src      = rst_n & pcs;
  assign reg2loc     = rst_n & r2l;
  assign alu_src     = rst_n & asrc;
  assign mem_to_reg  = rst_n & m2r;
  assign reg_write   = rst_n & rw;
  assign alu_op      = rst_n ? aop : ALU_ADD;
  assign retire      = rst_n & ret;
  assign illegal     = rst_n & ill;
  assign bus_error   = rst_n & berr;
  assign retired_cnt = rst_n ? cnt_q : '0;
  assign state       = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam int CW = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, irw, pcw, pcs, r2l, asrc, m2r, rw;
    logic [1:0] aop;
    logic       ret, ill, berr;
    logic [3:0] cnt;
  } vec_t;

  typedef struct packed {
    vec_t m;
    vec_t t;
  } pair_t;

  typedef enum int { K_R, K_LDUR, K_STUR, K_CBZ, K_B, K_ILL } kind_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        req_m, we_m, irw_m, pcw_m, pcs_m, r2l_m, asrc_m, m2r_m, rw_m, ret_m, ill_m, berr_m;
  logic [1:0]  aop_m;
  logic [CW-1:0] cnt_m;
  logic [2:0]  st_m;
  logic        req_t, we_t, irw_t, pcw_t, pcs_t, r2l_t, asrc_t, m2r_t, rw_t, ret_t, ill_t, berr_t;
  logic [1:0]  aop_t;
  logic [CW-1:0] cnt_t;
  logic [2:0]  st_t;

  vec_t act_m, act_t;
  assign act_m = {st_m, req_m, we_m, irw_m, pcw_m, pcs_m, r2l_m, asrc_m, m2r_m, rw_m,
                  aop_m, ret_m, ill_m, berr_m, cnt_m};
  assign act_t = {st_t, req_t, we_t, irw_t, pcw_t, pcs_t, r2l_t, asrc_t, m2r_t, rw_t,
                  aop_t, ret_t, ill_t, berr_t, cnt_t};

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(CW), .TRAP_ILLEGAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(req_m), .mem_we(we_m), .ir_write(irw_m), .pc_write(pcw_m), .pc_src(pcs_m),
    .reg2loc(r2l_m), .alu_src(asrc_m), .mem_to_reg(m2r_m), .reg_write(rw_m),
    .alu_op(aop_m), .retire(ret_m), .illegal(ill_m), .bus_error(berr_m),
    .retired_cnt(cnt_m), .state(st_m)
  );

  multicycle_control_fsm #(.CNT_W(CW), .TRAP_ILLEGAL(1)) dut_trap (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(req_t), .mem_we(we_t), .ir_write(irw_t), .pc_write(pcw_t), .pc_src(pcs_t),
    .reg2loc(r2l_t), .alu_src(asrc_t), .mem_to_reg(m2r_t), .reg_write(rw_t),
    .alu_op(aop_t), .retire(ret_t), .illegal(ill_t), .bus_error(berr_t),
    .retired_cnt(cnt_t), .state(st_t)
  );

  // Scoreboard and reference state
  pair_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;
  bit    trapped = 1'b0;
  int    trap_cnt = 0;
  int    txn = 0;

  // Monitor: one expected pair per clock cycle, compared mid-cycle.
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        p = sbq.pop_front();
        checks++;
        if (act_m !== p.m) begin
          errors++;
          $display("FAIL ctl_vec t=%0t got=%h want=%h (state got=%0d want=%0d)",
                   $time, act_m, p.m, act_m.st, p.m.st);
        end
        checks++;
        if (act_t !== p.t) begin
          errors++;
          $display("FAIL trap_vec t=%0t got=%h want=%h (state got=%0d want=%0d)",
                   $time, act_t, p.t, act_t.st, p.t.st);
        end
      end
    end
  end

  function automatic kind_e classify(input logic [10:0] op);
    if (op ==? 11'b1xx0101x000) return K_R;
    if (op == 11'b11111000010)  return K_LDUR;
    if (op == 11'b11111000000)  return K_STUR;
    if (op ==? 11'b10110100xxx) return K_CBZ;
    if (op ==? 11'b000101xxxxx) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [10:0] gen_op(input kind_e k);
    logic [10:0] op;
    op = 11'($urandom);
    case (k)
      K_R:    begin op[10] = 1'b1; op[7:4] = 4'b0101; op[2:0] = 3'b000; end
      K_LDUR: op = 11'b11111000010;
      K_STUR: op = 11'b11111000000;
      K_CBZ:  op[10:3] = 8'b10110100;
      K_B:    op[10:5] = 6'b000101;
      default: begin
        while (classify(op) != K_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t v(input int st);
    vec_t e;
    e = '0;
    e.st = st[2:0];
    e.cnt = exp_cnt[3:0];
    return e;
  endfunction

  // Latency picker: mostly short, with the 15-cycle boundary on both sides.
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return $urandom_range(0, 3);
    if (r < 16) return 14;
    if (r < 18) return 15;
    return 0;
  endfunction

  task automatic step(input logic [10:0] op, input logic z, input logic rdy,
                      input logic rst, input vec_t e);
    pair_t p;
    vec_t  t;
    @(posedge clk);
    #1;
    rst_n = rst;
    opcode = op;
    zero = z;
    mem_ready = rdy;
    if (!rst) begin
      trapped = 1'b0;
      t = '0;
    end else if (trapped) begin
      t = '0;
      t.st = 3'd5;
      t.cnt = trap_cnt[3:0];
    end else begin
      t = e;
    end
    p.m = e;
    p.t = t;
    sbq.push_back(p);
  endtask

  // Fetch until an attempt completes; an attempt of 15 idle cycles times out.
  task automatic do_fetch(input int lat0);
    int   lat;
    int   i;
    bit   done;
    vec_t e;
    lat = lat0;
    done = 1'b0;
    while (!done) begin
      i = 0;
      while (1) begin
        e = v(0);
        e.req = 1'b1;
        if (i == lat) begin
          e.irw = 1'b1;
          e.pcw = 1'b1;
          step(rop(), rb(), 1'b1, 1'b1, e);
          done = 1'b1;
          break;
        end else if (i == 14) begin
          e.berr = 1'b1;
          step(rop(), rb(), 1'b0, 1'b1, e);
          break;
        end else begin
          step(rop(), rb(), 1'b0, 1'b1, e);
        end
        i++;
      end
      lat = $urandom_range(0, 3);
    end
  endtask

  task automatic run_instr(input kind_e k, input logic [10:0] op, input logic z,
                           input int flat, input int mlat);
    vec_t e;
    int   i;
    bit   ok;
    bit   st;
    txn++;
    $display("txn %0d kind=%s op=%b zero=%0d fetch_lat=%0d mem_lat=%0d cnt_before=%0d",
             txn, k.name(), op, z, flat, mlat, exp_cnt);
    do_fetch(flat);
    e = v(1);
    if (k == K_ILL) e.ill = 1'b1;
    step(op, rb(), rb(), 1'b1, e);
    if (k == K_ILL) begin
      if (!trapped) begin
        trapped = 1'b1;
        trap_cnt = exp_cnt;
      end
      return;
    end
    e = v(2);
    case (k)
      K_R:    e.aop = 2'b10;
      K_LDUR: e.asrc = 1'b1;
      K_STUR: begin e.asrc = 1'b1; e.r2l = 1'b1; end
      K_CBZ:  begin e.r2l = 1'b1; e.aop = 2'b01; e.pcw = z; e.pcs = z; e.ret = 1'b1; end
      default: begin e.pcw = 1'b1; e.pcs = 1'b1; e.ret = 1'b1; end
    endcase
    step(rop(), z, rb(), 1'b1, e);
    if (e.ret) begin
      exp_cnt = (exp_cnt + 1) % 16;
      return;
    end
    if (k == K_LDUR || k == K_STUR) begin
      st = (k == K_STUR);
      ok = 1'b0;
      i = 0;
      while (1) begin
        e = v(3);
        e.req = 1'b1;
        e.we = st;
        e.r2l = st;
        e.asrc = 1'b1;
        if (i == mlat) begin
          e.ret = st;
          step(rop(), rb(), 1'b1, 1'b1, e);
          if (st) exp_cnt = (exp_cnt + 1) % 16;
          ok = 1'b1;
          break;
        end else if (i == 14) begin
          e.berr = 1'b1;
          step(rop(), rb(), 1'b0, 1'b1, e);
          break;
        end else begin
          step(rop(), rb(), 1'b0, 1'b1, e);
        end
        i++;
      end
      if (!ok || st) return;
    end
    e = v(4);
    e.rw = 1'b1;
    e.m2r = (k == K_LDUR);
    e.asrc = (k == K_LDUR);
    e.aop = (k == K_R) ? 2'b10 : 2'b00;
    e.ret = 1'b1;
    step(rop(), rb(), rb(), 1'b1, e);
    exp_cnt = (exp_cnt + 1) % 16;
  endtask

  initial begin
    vec_t  e;
    kind_e k;
    int    w;

    // Reset held: every output low.
    repeat (3) step(rop(), rb(), rb(), 1'b0, '0);
    exp_cnt = 0;

    // Directed cases
    run_instr(K_R,    11'b10001011000, 1'b0, 0, 0);
    run_instr(K_LDUR, 11'b11111000010, 1'b0, 0, 3);
    run_instr(K_STUR, 11'b11111000000, 1'b0, 1, 2);
    run_instr(K_CBZ,  gen_op(K_CBZ),   1'b1, 0, 0);
    run_instr(K_CBZ,  gen_op(K_CBZ),   1'b0, 0, 0);
    run_instr(K_R,    gen_op(K_R),     1'b0, 14, 0);   // ready on last allowed cycle
    run_instr(K_B,    gen_op(K_B),     1'b0, 20, 0);   // fetch timeout, then refetch
    run_instr(K_LDUR, 11'b11111000010, 1'b0, 0, 20);   // data timeout, no retire
    run_instr(K_STUR, 11'b11111000000, 1'b0, 0, 14);

    // Reset in the middle of a load's MEM phase.
    $display("txn reset_in_mem");
    do_fetch(0);
    e = v(1);
    step(11'b11111000010, rb(), rb(), 1'b1, e);
    e = v(2); e.asrc = 1'b1;
    step(rop(), rb(), rb(), 1'b1, e);
    e = v(3); e.req = 1'b1; e.asrc = 1'b1;
    step(rop(), rb(), 1'b0, 1'b1, e);
    step(rop(), rb(), rb(), 1'b0, '0);
    exp_cnt = 0;

    // Illegal opcode: no retire; the trapping instance parks in TRAP.
    run_instr(K_ILL, 11'b00000000000, 1'b0, 0, 0);
    run_instr(K_R,   gen_op(K_R),     1'b0, 0, 0);

    // Counter wrap over 16 branches.
    for (int n = 0; n < 16; n++) run_instr(K_B, gen_op(K_B), rb(), 0, 0);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      k = kind_e'($urandom_range(0, 5));
      run_instr(k, gen_op(k), rb(), pick_lat(), pick_lat());
    end

    // Drain the scoreboard with a bounded wait.
    w = 0;
    while (sbq.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
